image_mem_responder: RTL and testbench

IMAGE_MEM_RESPONDER -- requirements
Module: image_mem_responder

---
 rtl/image_mem_responder_if.sv | 44 ++++
 rtl/image_mem_responder.sv | 180 ++++++++++++++++++
 tb/tb_image_mem_responder.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/image_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : image_mem_responder_if
// Description : Command/data bundle between the read/write controller and the
//               image memory responder. cmd_err exists only when
//               MEM_RESPONDER_ERR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface image_mem_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [1:0]        instruction;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_w;
    logic [DATA_W-1:0] data_w;
    logic [DATA_W-1:0] data_r;
    logic              busy;

`ifdef MEM_RESPONDER_ERR_EN
    logic              cmd_err;

    modport master (
        output instruction, addr_r, addr_w, data_w,
        input  data_r, busy, cmd_err
    );

    modport slave (
        input  instruction, addr_r, addr_w, data_w,
        output data_r, busy, cmd_err
    );
`else
    modport master (
        output instruction, addr_r, addr_w, data_w,
        input  data_r, busy
    );

    modport slave (
        input  instruction, addr_r, addr_w, data_w,
        output data_r, busy
    );
`endif
endinterface
`default_nettype wire

// File: rtl/image_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : image_mem_responder
// Description : Register-array image memory that serves one read or write per
//               controller command with a fixed busy window of ACCESS_LATENCY
//               cycles. Optional macro MEM_RESPONDER_ERR_EN adds the cmd_err
//               pulse for the illegal command.
// Revision    : 1.0 - initial release
// ============================================================================
module image_mem_responder #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int ACCESS_LATENCY = 2
) (
    input  wire                  clk,
    input  wire                  n_rst,
    image_mem_responder_if.slave bus
);

    localparam int         c_depth    = 2 ** ADDR_W;
    localparam logic [3:0] c_cnt_load = 4'(ACCESS_LATENCY - 1);

    localparam logic [1:0] c_st_idle       = 2'd0;
    localparam logic [1:0] c_st_read_wait  = 2'd1;
    localparam logic [1:0] c_st_write_wait = 2'd2;
    localparam logic [1:0] c_st_release    = 2'd3;

    localparam logic [1:0] c_ins_idle    = 2'b00;
    localparam logic [1:0] c_ins_read    = 2'b01;
    localparam logic [1:0] c_ins_write   = 2'b10;
    localparam logic [1:0] c_ins_illegal = 2'b11;

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic              r_busy;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_data_r;
    logic [DATA_W-1:0] r_mem [c_depth];

    logic [1:0]        w_state_nxt;
    logic [3:0]        w_cnt_nxt;
    logic              w_busy_nxt;
    logic              w_latch_rd;
    logic              w_latch_wr;
    logic              w_rd_done;
    logic              w_wr_en;

`ifdef MEM_RESPONDER_ERR_EN
    logic              r_cmd_err;
    logic              w_cmd_err_nxt;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= c_st_idle;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        w_latch_rd  = 1'b0;
        w_latch_wr  = 1'b0;
        w_rd_done   = 1'b0;
        w_wr_en     = 1'b0;
`ifdef MEM_RESPONDER_ERR_EN
        w_cmd_err_nxt = 1'b0;
`endif
        case (r_state)
            c_st_idle: begin
                case (bus.instruction)
                    c_ins_read: begin
                        w_latch_rd  = 1'b1;
                        w_cnt_nxt   = c_cnt_load;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = c_st_read_wait;
                    end
                    c_ins_write: begin
                        w_latch_wr  = 1'b1;
                        w_cnt_nxt   = c_cnt_load;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = c_st_write_wait;
                    end
                    c_ins_illegal: begin
`ifdef MEM_RESPONDER_ERR_EN
                        w_cmd_err_nxt = 1'b1;
`endif
                    end
                    default: begin
                    end
                endcase
            end
            c_st_read_wait: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_rd_done   = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = c_st_release;
                end
            end
            c_st_write_wait: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_wr_en     = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = c_st_release;
                end
            end
            c_st_release: begin
                // A held start level must not trigger a second access.
                w_busy_nxt = 1'b0;
                if (bus.instruction == c_ins_idle) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Only values captured at acceptance are used; later input changes are ignored.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_latch_rd) begin
            r_addr  <= bus.addr_r;
        end else if (w_latch_wr) begin
            r_addr  <= bus.addr_w;
            r_wdata <= bus.data_w;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_data_r <= '0;
        end else if (w_rd_done) begin
            r_data_r <= r_mem[r_addr];
        end
    end

`ifdef MEM_RESPONDER_ERR_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cmd_err <= 1'b0;
        end else begin
            r_cmd_err <= w_cmd_err_nxt;
        end
    end

    assign bus.cmd_err = r_cmd_err;
`endif

    assign bus.data_r = r_data_r;
    assign bus.busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_image_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_image_mem_responder
// Description : Drives three responders (latency 2, 1, 15) with one command
//               stream and compares against an array-based memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_image_mem_responder;

    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int N   = 3;
    localparam int WIN = 24;
    localparam int LAT [N] = '{2, 1, 15};

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic [1:0]    instr = 2'b00;
    logic [AW-1:0] a_r = '0;
    logic [AW-1:0] a_w = '0;
    logic [DW-1:0] d_w = '0;

    always #5 clk = ~clk;

    image_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
    image_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
    image_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();

    assign bus0.instruction = instr;
    assign bus0.addr_r      = a_r;
    assign bus0.addr_w      = a_w;
    assign bus0.data_w      = d_w;
    assign bus1.instruction = instr;
    assign bus1.addr_r      = a_r;
    assign bus1.addr_w      = a_w;
    assign bus1.data_w      = d_w;
    assign bus2.instruction = instr;
    assign bus2.addr_r      = a_r;
    assign bus2.addr_w      = a_w;
    assign bus2.data_w      = d_w;

    image_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_LATENCY(2))
        dut_l2 (.clk(clk), .n_rst(n_rst), .bus(bus0));
    image_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_LATENCY(1))
        dut_l1 (.clk(clk), .n_rst(n_rst), .bus(bus1));
    image_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_LATENCY(15))
        dut_l15 (.clk(clk), .n_rst(n_rst), .bus(bus2));

    logic          busy_v [N];
    logic [DW-1:0] dr_v   [N];
    assign busy_v[0] = bus0.busy;
    assign busy_v[1] = bus1.busy;
    assign busy_v[2] = bus2.busy;
    assign dr_v[0]   = bus0.data_r;
    assign dr_v[1]   = bus1.data_r;
    assign dr_v[2]   = bus2.data_r;

`ifdef MEM_RESPONDER_ERR_EN
    logic ce_v [N];
    assign ce_v[0] = bus0.cmd_err;
    assign ce_v[1] = bus1.cmd_err;
    assign ce_v[2] = bus2.cmd_err;
`endif

    // Reference model: plain memory array plus the last value a read returned.
    logic [DW-1:0] mm [2**AW];
    logic [DW-1:0] exp_dr;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2**AW; i++) mm[i] = '0;
        exp_dr = '0;
    endtask

    // One command, held for 'hold' edges; busy width and read data checked per DUT.
    task automatic do_access(input logic [1:0] ins, input logic [AW-1:0] ra,
                             input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                             input int hold, input bit scramble, input string tag);
        int            width [N];
        bit            fell  [N];
        logic [DW-1:0] prev_dr;
        @(negedge clk);
        instr = ins; a_r = ra; a_w = wa; d_w = wd;
        @(posedge clk);
        prev_dr = exp_dr;
        if (ins == 2'b01) exp_dr = mm[ra];
        else if (ins == 2'b10) mm[wa] = wd;
        for (int d = 0; d < N; d++) begin
            width[d] = 0;
            fell[d]  = 1'b0;
        end
        for (int c = 0; c < WIN; c++) begin
            @(negedge clk);
            for (int d = 0; d < N; d++) begin
                if (busy_v[d] !== 1'b0) begin
                    width[d]++;
                    if (c == 0)
                        chk($sformatf("%s/L%0d/data_r_during_busy", tag, LAT[d]), dr_v[d], prev_dr);
                end else if (!fell[d]) begin
                    fell[d] = 1'b1;
                    chk($sformatf("%s/L%0d/data_r_at_fall", tag, LAT[d]), dr_v[d], exp_dr);
                end
            end
            if (scramble && c == 0) begin
                a_r = 8'd7; a_w = ~wa; d_w = ~wd;
            end
            if (c + 1 >= hold) instr = 2'b00;
        end
        for (int d = 0; d < N; d++)
            chk($sformatf("%s/L%0d/busy_width", tag, LAT[d]), width[d], LAT[d]);
    endtask

    task automatic do_illegal(input string tag);
        @(negedge clk);
        instr = 2'b11;
        @(posedge clk);
        @(negedge clk);
        instr = 2'b00;
        for (int d = 0; d < N; d++) begin
            chk($sformatf("%s/L%0d/busy", tag, LAT[d]), busy_v[d], 1'b0);
`ifdef MEM_RESPONDER_ERR_EN
            chk($sformatf("%s/L%0d/cmd_err_pulse", tag, LAT[d]), ce_v[d], 1'b1);
`endif
        end
        @(negedge clk);
        for (int d = 0; d < N; d++) begin
            chk($sformatf("%s/L%0d/busy_after", tag, LAT[d]), busy_v[d], 1'b0);
            chk($sformatf("%s/L%0d/data_r_kept", tag, LAT[d]), dr_v[d], exp_dr);
`ifdef MEM_RESPONDER_ERR_EN
            chk($sformatf("%s/L%0d/cmd_err_clear", tag, LAT[d]), ce_v[d], 1'b0);
`endif
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        #12;
        for (int d = 0; d < N; d++) begin
            chk($sformatf("reset/L%0d/busy", LAT[d]), busy_v[d], 1'b0);
            chk($sformatf("reset/L%0d/data_r", LAT[d]), dr_v[d], '0);
`ifdef MEM_RESPONDER_ERR_EN
            chk($sformatf("reset/L%0d/cmd_err", LAT[d]), ce_v[d], 1'b0);
`endif
        end
        @(negedge clk);
        n_rst = 1'b1;

        do_access(2'b01, 8'd50, 8'd0, 8'd0, 1, 1'b0, "rd50_fresh");
        do_access(2'b10, 8'd0, 8'd100, 8'd255, 5, 1'b0, "wr100_held");
        do_access(2'b01, 8'd100, 8'd0, 8'd0, 1, 1'b0, "rd100");
        do_access(2'b10, 8'd0, 8'd50, 8'd200, 1, 1'b1, "wr50_scramble");
        do_access(2'b01, 8'd50, 8'd0, 8'd0, 1, 1'b1, "rd50_toggle");
        do_illegal("illegal");
        do_access(2'b01, 8'd100, 8'd0, 8'd0, 1, 1'b0, "rd100_after_ill");

        // Reset in the middle of a write: busy drops at once, nothing is stored.
        @(negedge clk);
        instr = 2'b10; a_w = 8'd9; d_w = 8'd240;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid/L2/busy_before", busy_v[0], 1'b1);
        n_rst = 1'b0;
        instr = 2'b00;
        #1;
        for (int d = 0; d < N; d++) begin
            chk($sformatf("rst_mid/L%0d/busy", LAT[d]), busy_v[d], 1'b0);
            chk($sformatf("rst_mid/L%0d/data_r", LAT[d]), dr_v[d], '0);
        end
        model_reset();
        @(negedge clk);
        n_rst = 1'b1;
        do_access(2'b01, 8'd9, 8'd0, 8'd0, 1, 1'b0, "rd9_after_rst");
        do_access(2'b01, 8'd100, 8'd0, 8'd0, 1, 1'b0, "rd100_after_rst");

        for (int k = 0; k < 30; k++) begin
            int unsigned   op;
            logic [AW-1:0] ad;
            logic [DW-1:0] dt;
            op = $urandom_range(0, 8);
            ad = AW'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) ad = AW'($urandom);
            dt = DW'($urandom);
            if (op < 4)
                do_access(2'b10, AW'($urandom), ad, dt, $urandom_range(1, 4),
                          1'($urandom), $sformatf("rnd%0d_wr", k));
            else if (op < 8)
                do_access(2'b01, ad, AW'($urandom), DW'($urandom), $urandom_range(1, 4),
                          1'($urandom), $sformatf("rnd%0d_rd", k));
            else
                do_illegal($sformatf("rnd%0d_ill", k));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
